// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and operation codes for the branch resolve unit.
// The operation encodings mirror the ALU codes the execute stage already uses.
package branch_resolve_unit_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned OP_W         = 4;

    typedef enum logic [OP_W-1:0] {
        ALU_SUB    = 4'h1,
        ALU_BRANCH = 4'hA,
        ALU_BLT    = 4'hB,
        ALU_BLTU   = 4'hC,
        ALU_BGE    = 4'hD,
        ALU_BGEU   = 4'hE,
        ALU_JAL    = 4'hF
    } alu_op_e;

    // Direction flags carried alongside the registered result.
    typedef struct packed {
        logic taken;
        logic mispredict;
    } br_flags_t;

    function automatic logic is_branch_op(input logic [OP_W-1:0] op);
        case (op)
            ALU_SUB, ALU_BRANCH, ALU_BLT, ALU_BLTU,
            ALU_BGE, ALU_BGEU, ALU_JAL: is_branch_op = 1'b1;
            default:                    is_branch_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/branch_resolve_unit_bht_counter_array.sv
// Table of saturating direction counters: one combinational read port
// (MSB only) and one saturating update port. Reads see pre-update state.
module branch_resolve_unit_bht_counter_array
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned ENTRIES  = 64,
    parameter int unsigned CNT_BITS = 2,
    localparam int unsigned IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_taken_c_o,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);

    // Weakly-not-taken: MSB clear, all lower bits set (zero when single-bit).
    localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    logic [CNT_BITS-1:0] cnt_q [ENTRIES];
    logic [CNT_BITS-1:0] cnt_cur_c;
    logic [CNT_BITS-1:0] cnt_d;

    assign rd_taken_c_o = cnt_q[rd_idx_i][CNT_BITS-1];

    always_comb begin
        cnt_cur_c = cnt_q[upd_idx_i];
        cnt_d     = cnt_cur_c;
        if (upd_taken_i) begin
            if (cnt_cur_c != CNT_MAX) begin
                cnt_d = cnt_cur_c + CNT_BITS'(1);
            end
        end else if (cnt_cur_c != '0) begin
            cnt_d = cnt_cur_c - CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                cnt_q[i] <= CNT_WNT;
            end
        end else if (upd_en_i) begin
            cnt_q[upd_idx_i] <= cnt_d;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Pipelined branch/jump resolver: condition, target and redirect PC, mispredict
// detection, BHT training and statistics, with a one-entry output register.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned XLEN        = XLEN_DEFAULT,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned CNT_BITS    = 2,
    parameter int unsigned STAT_BITS   = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OP_W-1:0]      operation,
    input  logic [XLEN-1:0]      pc,
    input  logic [XLEN-1:0]      rs1,
    input  logic [XLEN-1:0]      rs2,
    input  logic [XLEN-1:0]      imm,
    input  logic                 pred_taken,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_taken,
    output logic                 out_mispredict,
    output logic [XLEN-1:0]      out_target,
    output logic [XLEN-1:0]      out_redirect_pc,
    input  logic [XLEN-1:0]      lookup_pc,
    output logic                 lookup_taken,
    output logic [STAT_BITS-1:0] stat_branches,
    output logic [STAT_BITS-1:0] stat_mispredicts
);

    localparam int unsigned IDX_W = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;

    logic                 accept_c;
    logic                 is_br_c;
    logic                 taken_c;
    logic                 mispredict_c;
    logic [XLEN-1:0]      target_c;
    logic [XLEN-1:0]      seq_pc_c;
    logic [IDX_W-1:0]     upd_idx_c;
    logic [IDX_W-1:0]     rd_idx_c;

    logic                 out_valid_q,    out_valid_d;
    br_flags_t            flags_q,        flags_d;
    logic [XLEN-1:0]      target_q,       target_d;
    logic [XLEN-1:0]      redirect_q,     redirect_d;
    logic [STAT_BITS-1:0] stat_br_q,      stat_br_d;
    logic [STAT_BITS-1:0] stat_mis_q,     stat_mis_d;

    logic                 unused_lookup_bits;

    assign in_ready     = !flush && (!out_valid_q || out_ready);
    assign accept_c     = in_valid && in_ready;
    assign is_br_c      = is_branch_op(operation);
    assign target_c     = pc + imm;
    assign seq_pc_c     = pc + XLEN'(4);
    assign mispredict_c = taken_c != pred_taken;

    // Direction resolution; unrecognised codes resolve not-taken.
    always_comb begin
        taken_c = 1'b0;
        case (operation)
            ALU_SUB:    taken_c = rs1 == rs2;
            ALU_BRANCH: taken_c = rs1 != rs2;
            ALU_BLT:    taken_c = $signed(rs1) <  $signed(rs2);
            ALU_BGE:    taken_c = $signed(rs1) >= $signed(rs2);
            ALU_BLTU:   taken_c = rs1 <  rs2;
            ALU_BGEU:   taken_c = rs1 >= rs2;
            ALU_JAL:    taken_c = 1'b1;
            default:    taken_c = 1'b0;
        endcase
    end

    // Output register and statistics next-state; flush wins over everything.
    always_comb begin
        out_valid_d = out_valid_q;
        flags_d     = flags_q;
        target_d    = target_q;
        redirect_d  = redirect_q;
        stat_br_d   = stat_br_q;
        stat_mis_d  = stat_mis_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept_c) begin
            out_valid_d        = 1'b1;
            flags_d.taken      = taken_c;
            flags_d.mispredict = mispredict_c;
            target_d           = target_c;
            redirect_d         = taken_c ? target_c : seq_pc_c;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept_c && is_br_c) begin
            stat_br_d = stat_br_q + STAT_BITS'(1);
            if (mispredict_c) begin
                stat_mis_d = stat_mis_q + STAT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            flags_q     <= '0;
            target_q    <= '0;
            redirect_q  <= '0;
            stat_br_q   <= '0;
            stat_mis_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            flags_q     <= flags_d;
            target_q    <= target_d;
            redirect_q  <= redirect_d;
            stat_br_q   <= stat_br_d;
            stat_mis_q  <= stat_mis_d;
        end
    end

    assign out_valid        = out_valid_q;
    assign out_taken        = flags_q.taken;
    assign out_mispredict   = flags_q.mispredict;
    assign out_target       = target_q;
    assign out_redirect_pc  = redirect_q;
    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;

    // Word-aligned PCs: index starts above the two byte-offset bits.
    assign upd_idx_c = pc[IDX_W+1:2];
    assign rd_idx_c  = lookup_pc[IDX_W+1:2];
    assign unused_lookup_bits = ^{lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0]};

    branch_resolve_unit_bht_counter_array #(
        .ENTRIES  (BHT_ENTRIES),
        .CNT_BITS (CNT_BITS)
    ) u_bht (
        .clk          (clk),
        .reset_n      (reset_n),
        .rd_idx_i     (rd_idx_c),
        .rd_taken_c_o (lookup_taken),
        .upd_en_i     (accept_c && is_br_c),
        .upd_idx_i    (upd_idx_c),
        .upd_taken_i  (taken_c)
    );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomised and directed bench for branch_resolve_unit against a
// cycle-level behavioural model (default parameters).
module tb_branch_resolve_unit;
    import branch_resolve_unit_pkg::*;

    localparam int NBHT   = 64;
    localparam int CNTMAX = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  operation;
    logic [31:0] pc, rs1, rs2, imm;
    logic        pred_taken;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic        out_taken, out_mispredict;
    logic [31:0] out_target, out_redirect_pc;
    logic [31:0] lookup_pc;
    logic        lookup_taken;
    logic [31:0] stat_branches, stat_mispredicts;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int          bht [NBHT];
    logic        m_valid, m_taken, m_mis;
    logic [31:0] m_target, m_redir, m_stb, m_stm;

    branch_resolve_unit dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .operation(operation), .pc(pc), .rs1(rs1), .rs2(rs2), .imm(imm),
        .pred_taken(pred_taken), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_taken(out_taken), .out_mispredict(out_mispredict),
        .out_target(out_target), .out_redirect_pc(out_redirect_pc),
        .lookup_pc(lookup_pc), .lookup_taken(lookup_taken),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int bidx(input logic [31:0] a);
        return int'((a >> 2) % 32'(NBHT));
    endfunction

    function automatic logic ref_valid_op(input logic [3:0] op);
        return op == ALU_SUB || op == ALU_BRANCH || op == ALU_BLT || op == ALU_BLTU ||
               op == ALU_BGE || op == ALU_BGEU || op == ALU_JAL;
    endfunction

    function automatic logic ref_taken(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        if (op == ALU_SUB)    return a == b;
        if (op == ALU_BRANCH) return a != b;
        if (op == ALU_BLT)    return sa < sb;
        if (op == ALU_BGE)    return sa >= sb;
        if (op == ALU_BLTU)   return a < b;
        if (op == ALU_BGEU)   return a >= b;
        if (op == ALU_JAL)    return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NBHT; i++) bht[i] = 1;
        m_valid = 0; m_taken = 0; m_mis = 0;
        m_target = 0; m_redir = 0; m_stb = 0; m_stm = 0;
    endtask

    task automatic check_reset_outputs();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_taken", out_taken, 0);
        check("rst_out_mis", out_mispredict, 0);
        check("rst_out_target", out_target, 0);
        check("rst_out_redir", out_redirect_pc, 0);
        check("rst_stat_br", stat_branches, 0);
        check("rst_stat_mis", stat_mispredicts, 0);
    endtask

    // One cycle: drive at posedge+1, check combinational outputs, advance the
    // model, then check registered outputs at the next posedge+1.
    task automatic step(input logic v, input logic [3:0] op, input logic [31:0] p,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                        input logic pr, input logic fl, input logic ordy, input logic [31:0] lp);
        logic rdy, acc, t;
        logic [31:0] tgt;
        in_valid = v; operation = op; pc = p; rs1 = a; rs2 = b; imm = im;
        pred_taken = pr; flush = fl; out_ready = ordy; lookup_pc = lp;
        #1;
        rdy = !fl && (!m_valid || ordy);
        check("in_ready", in_ready, rdy);
        check("lookup_taken", lookup_taken, bht[bidx(lp)] >= 2);
        acc = v && rdy;
        t   = ref_taken(op, a, b);
        tgt = p + im;
        if (fl) m_valid = 0;
        else if (acc) begin
            m_valid = 1; m_taken = t; m_mis = (t != pr);
            m_target = tgt; m_redir = t ? tgt : p + 32'd4;
        end else if (ordy) m_valid = 0;
        if (acc && ref_valid_op(op)) begin
            m_stb++;
            if (t != pr) m_stm++;
            if (t) bht[bidx(p)] = (bht[bidx(p)] < CNTMAX) ? bht[bidx(p)] + 1 : CNTMAX;
            else   bht[bidx(p)] = (bht[bidx(p)] > 0) ? bht[bidx(p)] - 1 : 0;
        end
        @(posedge clk);
        #1;
        check("out_valid", out_valid, m_valid);
        if (m_valid) begin
            check("out_taken", out_taken, m_taken);
            check("out_mispredict", out_mispredict, m_mis);
            check("out_target", out_target, m_target);
            check("out_redirect", out_redirect_pc, m_redir);
        end
        check("stat_branches", stat_branches, m_stb);
        check("stat_mispredicts", stat_mispredicts, m_stm);
    endtask

    logic [3:0] ops [9];

    initial begin
        ops = '{ALU_SUB, ALU_BRANCH, ALU_BLT, ALU_BLTU, ALU_BGE, ALU_BGEU, ALU_JAL, 4'h0, 4'h7};
        in_valid = 0; operation = 0; pc = 0; rs1 = 0; rs2 = 0; imm = 0;
        pred_taken = 0; flush = 0; out_ready = 1; lookup_pc = 0;
        reset_n = 0;
        model_reset();
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #3 reset_n = 1;
        @(posedge clk);
        #1;

        // BEQ taken with wrong prediction
        step(1, ALU_SUB, 32'h100, 5, 5, 32'h20, 0, 0, 1, 32'h100);
        check("tp_beq_target", out_target, 32'h120);
        check("tp_beq_redir", out_redirect_pc, 32'h120);
        check("tp_beq_mis", out_mispredict, 1);
        check("tp_beq_stat_mis", stat_mispredicts, 1);

        // Signed vs unsigned compares
        step(1, ALU_BLT, 32'h200, 32'hFFFFFFFF, 1, 8, 1, 0, 1, 0);
        check("tp_blt_taken", out_taken, 1);
        step(1, ALU_BLTU, 32'h200, 32'hFFFFFFFF, 1, 8, 1, 0, 1, 0);
        check("tp_bltu_taken", out_taken, 0);
        step(1, ALU_BGE, 32'h200, 32'h80000000, 32'h80000000, 8, 0, 0, 1, 0);
        check("tp_bge_taken", out_taken, 1);

        // BHT training and saturation at pc 0x40
        for (int i = 0; i < 3; i++) step(1, ALU_BRANCH, 32'h40, 1, 2, 16, 0, 0, 1, 32'h40);
        for (int i = 0; i < 4; i++) step(1, ALU_SUB, 32'h40, 1, 2, 16, 1, 0, 1, 32'h40);
        step(0, ALU_SUB, 0, 0, 0, 0, 0, 0, 1, 32'h40);
        check("tp_bht_floor", lookup_taken, 0);

        // Backpressure then release
        step(1, ALU_JAL, 32'h300, 0, 0, 32'h10, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, ALU_SUB, 32'h44, 3, 3, 4, 0, 0, 0, 32'h44);
        check("tp_bp_target", out_target, 32'h310);
        for (int i = 0; i < 3; i++) step(1, ALU_BGEU, 32'h48 + 32'(4 * i), 9, 32'(i), 4, 1, 0, 1, 32'h48);

        // PC wraparound
        step(1, ALU_JAL, 32'hFFFFFFFC, 0, 0, 8, 1, 0, 1, 0);
        check("tp_jal_wrap", out_target, 32'h4);
        step(1, ALU_SUB, 32'hFFFFFFFC, 1, 2, 8, 0, 0, 1, 0);
        check("tp_beq_wrap_redir", out_redirect_pc, 32'h0);

        // Flush with a held result and a pending request
        step(1, ALU_JAL, 32'h500, 0, 0, 4, 0, 0, 0, 0);
        step(1, ALU_JAL, 32'h504, 0, 0, 4, 0, 1, 0, 0);
        check("tp_flush_valid", out_valid, 0);

        // Randomised traffic with one asynchronous reset mid-stream
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] p, a, b;
            if (c == 1500) begin
                #1 reset_n = 0;
                model_reset();
                #1;
                check_reset_outputs();
                for (int k = 0; k < 4; k++) begin
                    lookup_pc = $urandom;
                    #1 check("rst_lookup", lookup_taken, 0);
                end
                reset_n = 1;
            end
            p = $urandom;
            if ($urandom_range(0, 3) != 0) p = p & 32'h1FC;
            a = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 7)) - 32'd3;
            b = ($urandom_range(0, 2) == 0) ? a : (($urandom_range(0, 1) != 0) ? $urandom
                                                   : 32'($urandom_range(0, 7)) - 32'd3);
            step($urandom_range(0, 4) != 0, ops[$urandom_range(0, 8)], p, a, b, $urandom,
                 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? p : ($urandom & 32'h1FC));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
